// File: rtl/gap_mem_pkg.sv
// Shared types and default geometry for the gap_tv memory responder.
package gap_mem_pkg;

  localparam int DEF_PORT_SIZE = 16;
  localparam int DEF_WORD_W    = 16;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_LINE_W    = DEF_PORT_SIZE * DEF_WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SERVE  = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  typedef logic [DEF_LINE_W-1:0] line_t;

endpackage

// File: rtl/gap_mem_responder_if.sv
// Host stream, kernel line port and status signals of the memory responder.
interface gap_mem_responder_if
  import gap_mem_pkg::*;
#(
  parameter int PORT_SIZE = DEF_PORT_SIZE,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ADDR_W    = DEF_ADDR_W
);
  localparam int LINE_W = PORT_SIZE * WORD_W;

  logic [ADDR_W:0]   cfg_lines;
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [WORD_W-1:0] ld_data;
  logic              kern_en;
  logic              kern_done;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [LINE_W-1:0] din;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [LINE_W-1:0] dout;
  logic              ul_valid;
  logic              ul_ready;
  logic [WORD_W-1:0] ul_data;
  logic              ul_last;
  logic              err;

  // Host plus gap_tv side
  modport master (
    output cfg_lines, ld_start, ld_valid, ld_data, kern_done,
           ren, raddr, wen, waddr, dout, ul_ready,
    input  ld_ready, kern_en, din, ul_valid, ul_data, ul_last, err
  );

  // Responder side
  modport slave (
    input  cfg_lines, ld_start, ld_valid, ld_data, kern_done,
           ren, raddr, wen, waddr, dout, ul_ready,
    output ld_ready, kern_en, din, ul_valid, ul_data, ul_last, err
  );

endinterface

// File: rtl/gap_line_bank.sv
// 1R1W line RAM with a registered read port; read data is zero when the
// read enable was low on the previous edge.
module gap_line_bank #(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [2**ADDR_W];
  logic [LINE_W-1:0] rdata_reg;

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered, enable-gated read port
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end else begin
      rdata_reg <= '0;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/gap_mem_responder.sv
// Memory-side responder for gap_tv: loads the input bank from a host word
// stream, serves gap_tv line reads/writes, then streams the output bank back.
// PORT_SIZE is assumed to be a power of two of at least 4 so the lane
// counters wrap naturally and the next-line prefetch fits inside one line.
module gap_mem_responder
  import gap_mem_pkg::*;
#(
  parameter int PORT_SIZE = DEF_PORT_SIZE,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input logic               clk,
  input logic               rst,
  gap_mem_responder_if.slave bus
);

  localparam int LINE_W = PORT_SIZE * WORD_W;
  localparam int LANE_W = $clog2(PORT_SIZE);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PORT_SIZE - 1);
  localparam logic [CNT_W-1:0]  MAX_LINES = CNT_W'(2**ADDR_W);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  lines_reg;
  logic [CNT_W-1:0]  line_cnt_reg;
  logic [LANE_W-1:0] lane_cnt_reg;
  logic [LINE_W-1:0] pack_reg, pack_next;

  logic [CNT_W-1:0]  fetch_cnt_reg;
  logic [CNT_W-1:0]  ul_line_cnt_reg;
  logic [LANE_W-1:0] ul_lane_reg;
  logic [LINE_W-1:0] ul_line_reg;
  logic [LINE_W-1:0] pf_line_reg;
  logic              pf_valid_reg;
  logic              rd_pending_reg;
  logic              ul_valid_reg;
  logic              err_reg;

  logic [LINE_W-1:0] in_rdata, out_rdata;
  logic [WORD_W-1:0] ul_lanes [PORT_SIZE];

  logic in_idle, in_load, in_serve, in_unload;
  logic cfg_ok, start_ok;
  logic ld_beat, line_full, load_done;
  logic rd_en, wr_en;
  logic ul_accept, ul_line_end, ul_final, load_line, fetch_en;
  logic err_set;

  assign in_idle   = (state_reg == IDLE);
  assign in_load   = (state_reg == LOAD);
  assign in_serve  = (state_reg == SERVE);
  assign in_unload = (state_reg == UNLOAD);

  assign cfg_ok    = (bus.cfg_lines != '0) && (bus.cfg_lines <= MAX_LINES);
  assign start_ok  = in_idle && bus.ld_start && cfg_ok;

  assign ld_beat   = in_load && bus.ld_valid;
  assign line_full = ld_beat && (lane_cnt_reg == LAST_LANE);
  assign load_done = line_full && (line_cnt_reg == lines_reg - ONE);

  assign rd_en     = in_serve && bus.ren;
  assign wr_en     = in_serve && bus.wen;

  assign ul_accept   = ul_valid_reg && bus.ul_ready;
  assign ul_line_end = ul_accept && (ul_lane_reg == LAST_LANE);
  assign ul_final    = ul_line_end && (ul_line_cnt_reg == lines_reg - ONE);
  // Move the prefetched line into the shift slot when the slot is free
  assign load_line   = pf_valid_reg && (!ul_valid_reg || ul_line_end);
  // Only one read in flight and only when the prefetch slot is empty
  assign fetch_en    = in_unload && !pf_valid_reg && !rd_pending_reg &&
                       (fetch_cnt_reg < lines_reg);

  assign err_set = (bus.ld_start && !in_idle) ||
                   (bus.ld_start && in_idle && !cfg_ok) ||
                   (bus.kern_done && !in_serve) ||
                   (!in_serve && (bus.ren || bus.wen)) ||
                   (rd_en && ({1'b0, bus.raddr} >= lines_reg)) ||
                   (wr_en && ({1'b0, bus.waddr} >= lines_reg));

  // Packer: replace the current lane of the packing register with ld_data;
  // unpacker: split the unload line register into lanes
  generate
    for (genvar gi = 0; gi < PORT_SIZE; gi++) begin : g_lane
      assign pack_next[gi*WORD_W +: WORD_W] =
        (lane_cnt_reg == LANE_W'(gi)) ? bus.ld_data : pack_reg[gi*WORD_W +: WORD_W];
      assign ul_lanes[gi] = ul_line_reg[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok)      state_next = LOAD;
      LOAD:    if (load_done)     state_next = SERVE;
      SERVE:   if (bus.kern_done) state_next = UNLOAD;
      UNLOAD:  if (ul_final)      state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Load path: frame length capture, lane/line counters and packing register
  always_ff @(posedge clk) begin
    if (rst) begin
      lines_reg    <= '0;
      line_cnt_reg <= '0;
      lane_cnt_reg <= '0;
      pack_reg     <= '0;
    end else if (start_ok) begin
      lines_reg    <= bus.cfg_lines;
      line_cnt_reg <= '0;
      lane_cnt_reg <= '0;
    end else if (ld_beat) begin
      pack_reg     <= pack_next;
      lane_cnt_reg <= lane_cnt_reg + 1'b1;
      if (lane_cnt_reg == LAST_LANE) begin
        line_cnt_reg <= line_cnt_reg + 1'b1;
      end
    end
  end

  // Unload path: out_bank fetch, one-line prefetch slot and lane shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg   <= '0;
      ul_line_cnt_reg <= '0;
      ul_lane_reg     <= '0;
      ul_line_reg     <= '0;
      pf_line_reg     <= '0;
      pf_valid_reg    <= 1'b0;
      rd_pending_reg  <= 1'b0;
      ul_valid_reg    <= 1'b0;
    end else if (in_serve && bus.kern_done) begin
      fetch_cnt_reg   <= '0;
      ul_line_cnt_reg <= '0;
      ul_lane_reg     <= '0;
      pf_valid_reg    <= 1'b0;
      rd_pending_reg  <= 1'b0;
      ul_valid_reg    <= 1'b0;
    end else if (in_unload) begin
      rd_pending_reg <= fetch_en;
      if (fetch_en) begin
        fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
      end
      if (rd_pending_reg) begin
        pf_line_reg  <= out_rdata;
        pf_valid_reg <= 1'b1;
      end
      if (load_line) begin
        ul_line_reg  <= pf_line_reg;
        pf_valid_reg <= 1'b0;
        ul_valid_reg <= 1'b1;
        ul_lane_reg  <= '0;
      end else if (ul_line_end) begin
        ul_valid_reg <= 1'b0;
      end else if (ul_accept) begin
        ul_lane_reg <= ul_lane_reg + 1'b1;
      end
      if (ul_line_end) begin
        ul_line_cnt_reg <= ul_line_cnt_reg + 1'b1;
      end
    end
  end

  // Sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (err_set) begin
      err_reg <= 1'b1;
    end
  end

  gap_line_bank #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) in_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (line_full),
    .waddr (line_cnt_reg[ADDR_W-1:0]),
    .wdata (pack_next),
    .re    (rd_en),
    .raddr (bus.raddr),
    .rdata (in_rdata)
  );

  gap_line_bank #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) out_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (bus.waddr),
    .wdata (bus.dout),
    .re    (fetch_en),
    .raddr (fetch_cnt_reg[ADDR_W-1:0]),
    .rdata (out_rdata)
  );

  assign bus.ld_ready = in_load;
  assign bus.kern_en  = in_serve;
  assign bus.din      = in_rdata;
  assign bus.ul_valid = ul_valid_reg;
  assign bus.ul_data  = ul_lanes[ul_lane_reg];
  assign bus.ul_last  = ul_valid_reg && (ul_lane_reg == LAST_LANE) &&
                        (ul_line_cnt_reg == lines_reg - ONE);
  assign bus.err      = err_reg;

endmodule
